timer: RTL

TIMER -- requirements
Module: timer

---
 rtl/timer_pkg.sv | 37 +++
 rtl/timer_tapsel.sv | 52 +++++
 rtl/timer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_pkg
//  Description : Shared definitions for the FF05..FF07 timer block: FSM
//                encoding, TAC tap-select codes, register offsets, read mask.
//  Revision    : 1.0  initial release
// ============================================================================
package timer_pkg;

    // Overflow handling sequence
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OVF    = 2'd1,
        ST_RELOAD = 2'd2
    } state_t;

    // TAC[1:0] divider-tap selection codes
    localparam logic [1:0] TAC_SEL_4096   = 2'b00;
    localparam logic [1:0] TAC_SEL_262144 = 2'b01;
    localparam logic [1:0] TAC_SEL_65536  = 2'b10;
    localparam logic [1:0] TAC_SEL_16384  = 2'b11;

    // Register offsets within FF04..FF07 (FF04 belongs to clocks_reset)
    localparam logic [1:0] OFS_TIMA = 2'd1;
    localparam logic [1:0] OFS_TMA  = 2'd2;
    localparam logic [1:0] OFS_TAC  = 2'd3;

    // Unimplemented TAC bits read back as ones
    localparam logic [7:0] TAC_READ_MASK = 8'hF8;

    // Address bits arrive inverted; recover the register offset {A1,A0}
    function automatic logic [1:0] reg_offset(input logic na0, input logic na1);
        return {~na1, ~na0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/timer_tapsel.sv
`default_nettype none
// ============================================================================
//  Module      : timer_tapsel
//  Description : Selects the divider tap named by TAC, gates it with the TAC
//                enable and flags each falling edge of the gated signal.
//  Revision    : 1.0  initial release
// ============================================================================
module timer_tapsel
    import timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] tac,
    input  logic       tap_4096,
    input  logic       tap_16384,
    input  logic       tap_65536,
    input  logic       tap_262144,
    output logic       inc
);

    logic tap_sel;
    logic tsig;
    logic tprev;

    // Tap multiplexer driven by TAC[1:0]
    always_comb begin
        tap_sel = 1'b0;
        case (tac[1:0])
            TAC_SEL_4096:   tap_sel = tap_4096;
            TAC_SEL_262144: tap_sel = tap_262144;
            TAC_SEL_65536:  tap_sel = tap_65536;
            TAC_SEL_16384:  tap_sel = tap_16384;
            default:        tap_sel = 1'b0;
        endcase
    end

    // Enable gating happens before the edge detector, so disabling or
    // reselecting while the gated signal is high also counts as a fall.
    assign tsig = tap_sel & tac[2];
    assign inc  = tprev & ~tsig;

    // Previous-cycle copy of the gated tap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tprev <= 1'b0;
        end else begin
            tprev <= tsig;
        end
    end

endmodule
`default_nettype wire

// File: rtl/timer.sv
`default_nettype none
// ============================================================================
//  Module      : timer
//  Description : TIMA/TMA/TAC timer registers at FF05..FF07 with overflow,
//                one-cycle-delayed reload from TMA and timer interrupt pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module timer
    import timer_pkg::*;
(
    input  logic       boga1mhz,
    input  logic       nreset2,
    inout  wire  [7:0] d,
    input  logic       cpu_wr,
    input  logic       cpu_rd,
    input  logic       ff04_ff07,
    input  logic       tovy_na0,
    input  logic       tola_na1,
    input  logic       _4096hz,
    input  logic       _16384hz,
    input  logic       _65536hz,
    input  logic       _262144hz,
    output logic       int_timer
);

    logic [7:0] tima;
    logic [7:0] tma;
    logic [2:0] tac;
    state_t     state;
    state_t     state_next;
    logic [7:0] tima_next;
    logic       irq_next;
    logic       inc;

    logic [1:0] offset;
    logic       sel_tima;
    logic       sel_tma;
    logic       sel_tac;
    logic       wr_tima;
    logic       wr_tma;
    logic       wr_tac;
    logic       rd_en;
    logic [7:0] rd_data;

    // Register decode; FF04 (offset 0) is intentionally ignored here
    assign offset   = reg_offset(tovy_na0, tola_na1);
    assign sel_tima = ff04_ff07 & (offset == OFS_TIMA);
    assign sel_tma  = ff04_ff07 & (offset == OFS_TMA);
    assign sel_tac  = ff04_ff07 & (offset == OFS_TAC);
    assign wr_tima  = cpu_wr & sel_tima;
    assign wr_tma   = cpu_wr & sel_tma;
    assign wr_tac   = cpu_wr & sel_tac;
    assign rd_en    = cpu_rd & (sel_tima | sel_tma | sel_tac);

    timer_tapsel u_tapsel (
        .clk        (boga1mhz),
        .rst_n      (nreset2),
        .tac        (tac),
        .tap_4096   (_4096hz),
        .tap_16384  (_16384hz),
        .tap_65536  (_65536hz),
        .tap_262144 (_262144hz),
        .inc        (inc)
    );

    // Combinational read-back mux
    always_comb begin
        rd_data = 8'h00;
        if (sel_tima) begin
            rd_data = tima;
        end else if (sel_tma) begin
            rd_data = tma;
        end else if (sel_tac) begin
            rd_data = TAC_READ_MASK | {5'b00000, tac};
        end
    end

    assign d = rd_en ? rd_data : 8'hzz;

    // Next state, next TIMA and interrupt request for the overflow sequence
    always_comb begin
        state_next = state;
        tima_next  = tima;
        irq_next   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (wr_tima) begin
                    tima_next = d;
                end else if (inc) begin
                    tima_next = tima + 8'd1;
                    if (tima == 8'hFF) begin
                        state_next = ST_OVF;
                    end
                end
            end
            ST_OVF: begin
                // A CPU write here wins over the pending reload
                if (wr_tima) begin
                    tima_next  = d;
                    state_next = ST_IDLE;
                end else begin
                    tima_next  = tma;
                    state_next = ST_RELOAD;
                    irq_next   = 1'b1;
                end
            end
            ST_RELOAD: begin
                // TIMA writes are dropped; a TMA write propagates into TIMA
                state_next = ST_IDLE;
                if (wr_tma) begin
                    tima_next = d;
                end else if (inc) begin
                    tima_next = tima + 8'd1;
                    if (tima == 8'hFF) begin
                        state_next = ST_OVF;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge boga1mhz or negedge nreset2) begin
        if (!nreset2) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Timer registers and the registered interrupt pulse
    always_ff @(posedge boga1mhz or negedge nreset2) begin
        if (!nreset2) begin
            tima      <= 8'h00;
            tma       <= 8'h00;
            tac       <= 3'b000;
            int_timer <= 1'b0;
        end else begin
            tima      <= tima_next;
            int_timer <= irq_next;
            if (wr_tma) begin
                tma <= d;
            end
            if (wr_tac) begin
                tac <= d[2:0];
            end
        end
    end

endmodule
`default_nettype wire
